regfile_writeback: RTL and testbench

- Write-side front end for the 31-entry integer register file; the only agent allowed to drive its write port.
- Accepts results from the ALU (single-beat) and the load unit (valid/ready, raw word plus format info), formats load data, and queues requests in a small FIFO.
- Issues exactly one register write per cycle and publishes a pending-destination mask for hazard detection.
- The register file has no write enable and writes every clock, so an idle cycle is signalled by driving select 0, which the register file ignores.

---
 rtl/rv32i_pkg.sv | 19 +
 rtl/load_formatter.sv | 40 ++++
 rtl/regfile_writeback.sv | 138 +++++++++++++
 tb/tb_regfile_writeback.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the register-file write side: load funct3
// encodings, register/word widths and the queued write-request record.
package rv32i_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/load_formatter.sv
// Extracts and extends the addressed byte/halfword of a raw aligned memory
// word according to the load funct3; unknown encodings give 0 and flag illegal.
module load_formatter
  import rv32i_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            illegal
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Select the addressed lane, then extend it as the load type demands.
  always_comb begin
    byte_lane = rdata[7:0];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data      = '0;
    illegal   = 1'b0;

    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase

    case (funct3)
      LB:      data = {{24{byte_lane[7]}}, byte_lane};
      LH:      data = {{16{half_lane[15]}}, half_lane};
      LW:      data = rdata;
      LBU:     data = {24'd0, byte_lane};
      LHU:     data = {16'd0, half_lane};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side front end of the integer register file. Merges ALU results and
// formatted load data into a small FIFO, drains one write per cycle through a
// registered output stage (select 0 = idle) and exposes a pending-rd mask.
module regfile_writeback
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [2:0]            ld_funct3,
  input  logic [1:0]            ld_addr_lo,
  input  logic [XLEN-1:0]       ld_rdata,
  output logic                  ld_err,
  output logic [REG_ADDR_W-1:0] reg_write_select,
  output logic [XLEN-1:0]       reg_write_data,
  output logic [XLEN-1:0]       busy_mask
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) return '0;
    return p + 1'b1;
  endfunction

  wb_req_t                fifo_q [DEPTH];
  wb_req_t                fifo_d [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [REG_ADDR_W-1:0]  sel_q, sel_d;
  logic [XLEN-1:0]        data_q, data_d;
  logic                   ld_err_q, ld_err_d;

  logic [XLEN-1:0]        ld_fmt_data;
  logic                   ld_fmt_illegal;
  logic                   ld_fire, alu_fire, enq, deq;
  wb_req_t                enq_req;

  load_formatter u_load_formatter (
    .funct3  (ld_funct3),
    .addr_lo (ld_addr_lo),
    .rdata   (ld_rdata),
    .data    (ld_fmt_data),
    .illegal (ld_fmt_illegal)
  );

  // Handshake and enqueue selection; the load port wins and a full FIFO never passes through.
  always_comb begin
    ld_ready  = (count_q != CNT_FULL);
    alu_ready = (count_q != CNT_FULL) && !ld_valid;
    ld_fire   = ld_valid && ld_ready;
    alu_fire  = alu_valid && alu_ready;
    enq_req   = '{rd: '0, data: '0};
    enq       = 1'b0;
    if (ld_fire) begin
      enq_req = '{rd: ld_rd, data: ld_fmt_data};
      enq     = (ld_rd != '0);
    end else if (alu_fire) begin
      enq_req = '{rd: alu_rd, data: alu_data};
      enq     = (alu_rd != '0);
    end
    deq = (count_q != '0);
  end

  // Next FIFO contents, pointers, count and output-stage values.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sel_d    = '0;
    data_d   = '0;
    ld_err_d = ld_fire && ld_fmt_illegal;

    if (enq) begin
      fifo_d[wr_ptr_q] = enq_req;
      wr_ptr_d         = ptr_next(wr_ptr_q);
    end
    if (deq) begin
      sel_d    = fifo_q[rd_ptr_q].rd;
      data_d   = fifo_q[rd_ptr_q].data;
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    if (enq && !deq) count_d = count_q + 1'b1;
    else if (!enq && deq) count_d = count_q - 1'b1;
  end

  // State registers with synchronous active-low reset that drops all queued writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '{rd: '0, data: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sel_q    <= '0;
      data_q   <= '0;
      ld_err_q <= 1'b0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      ld_err_q <= ld_err_d;
    end
  end

  // Pending-destination mask: every live FIFO entry plus the write on the port.
  always_comb begin
    logic [PTR_W-1:0] p;
    busy_mask = '0;
    p         = rd_ptr_q;
    for (int j = 0; j < DEPTH; j++) begin
      if (CNT_W'(j) < count_q) busy_mask[fifo_q[p].rd] = 1'b1;
      p = ptr_next(p);
    end
    if (sel_q != '0) busy_mask[sel_q] = 1'b1;
    busy_mask[0] = 1'b0;
  end

  assign reg_write_select = sel_q;
  assign reg_write_data   = data_q;
  assign ld_err           = ld_err_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed testbench for regfile_writeback: ALU and load paths, load
// formatting, priority, back-to-back drain, illegal funct3, rd=0 and reset flush.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_rdata;
  logic        ld_err;
  logic [4:0]  reg_write_select;
  logic [31:0] reg_write_data;
  logic [31:0] busy_mask;

  int total = 0;
  int bad   = 0;

  regfile_writeback #(.DEPTH(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .alu_valid        (alu_valid),
    .alu_ready        (alu_ready),
    .alu_rd           (alu_rd),
    .alu_data         (alu_data),
    .ld_valid         (ld_valid),
    .ld_ready         (ld_ready),
    .ld_rd            (ld_rd),
    .ld_funct3        (ld_funct3),
    .ld_addr_lo       (ld_addr_lo),
    .ld_rdata         (ld_rdata),
    .ld_err           (ld_err),
    .reg_write_select (reg_write_select),
    .reg_write_data   (reg_write_data),
    .busy_mask        (busy_mask)
  );

  // 10 ns free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                               input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                               input logic [1:0] alo, input logic [31:0] rdata);
    alu_valid  = av;
    alu_rd     = ard;
    alu_data   = adata;
    ld_valid   = lv;
    ld_rd      = lrd;
    ld_funct3  = f3;
    ld_addr_lo = alo;
    ld_rdata   = rdata;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a single load, then check the formatted value on the write port.
  task automatic loadCase(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] alo, input logic [31:0] rdata, input logic [31:0] exp);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, rd, f3, alo, rdata);
    tick();
    idle();
    tick();
    checkOutput({tag, "_sel"}, 32'(reg_write_select), 32'(rd));
    checkOutput({tag, "_data"}, reg_write_data, exp);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b1;

    // Reset state
    checkOutput("rst_sel", 32'(reg_write_select), 32'd0);
    checkOutput("rst_data", reg_write_data, 32'd0);
    checkOutput("rst_busy", busy_mask, 32'd0);
    checkOutput("rst_err", 32'(ld_err), 32'd0);
    checkOutput("rst_ldrdy", 32'(ld_ready), 32'd1);

    // Single ALU write to x5
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    checkOutput("alu_ready", 32'(alu_ready), 32'd1);
    tick();
    idle();
    checkOutput("alu_q_sel", 32'(reg_write_select), 32'd0);
    checkOutput("alu_q_busy", busy_mask, 32'h0000_0020);
    tick();
    checkOutput("alu_sel", 32'(reg_write_select), 32'd5);
    checkOutput("alu_data", reg_write_data, 32'hDEADBEEF);
    checkOutput("alu_busy", busy_mask, 32'h0000_0020);
    tick();
    checkOutput("alu_done_sel", 32'(reg_write_select), 32'd0);
    checkOutput("alu_done_busy", busy_mask, 32'd0);

    // Load formatting
    loadCase("lb3", 5'd10, 3'b000, 2'd3, 32'h80FF_1234, 32'hFFFF_FF80);
    loadCase("lhu2", 5'd11, 3'b101, 2'd2, 32'h80FF_1234, 32'h0000_80FF);
    loadCase("lh1", 5'd12, 3'b001, 2'd1, 32'h80FF_1234, 32'h0000_1234);
    loadCase("lb1", 5'd13, 3'b000, 2'd1, 32'h80FF_1234, 32'h0000_0012);
    loadCase("lbu0", 5'd14, 3'b100, 2'd0, 32'h80FF_12B4, 32'h0000_00B4);
    loadCase("lh2", 5'd15, 3'b001, 2'd2, 32'h80FF_1234, 32'hFFFF_80FF);
    loadCase("lw", 5'd16, 3'b010, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    tick();

    // Load and ALU together: load wins, ALU follows
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 3'b010, 2'd0, 32'h33);
    checkOutput("pri_alu_rdy", 32'(alu_ready), 32'd0);
    checkOutput("pri_ld_rdy", 32'(ld_ready), 32'd1);
    tick();
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    checkOutput("pri_alu_rdy2", 32'(alu_ready), 32'd1);
    tick();
    idle();
    checkOutput("pri_sel3", 32'(reg_write_select), 32'd3);
    checkOutput("pri_data3", reg_write_data, 32'h33);
    tick();
    checkOutput("pri_sel4", 32'(reg_write_select), 32'd4);
    checkOutput("pri_data4", reg_write_data, 32'h44);
    tick();
    checkOutput("pri_idle", 32'(reg_write_select), 32'd0);

    // Back-to-back ALU stream drains in order
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
      checkOutput($sformatf("str_rdy%0d", i), 32'(alu_ready), 32'd1);
      tick();
      if (i >= 2) begin
        checkOutput($sformatf("str_sel%0d", i - 1), 32'(reg_write_select), 32'(i - 1));
        checkOutput($sformatf("str_data%0d", i - 1), reg_write_data, 32'h100 + 32'(i - 1));
      end
    end
    idle();
    tick();
    checkOutput("str_sel4", 32'(reg_write_select), 32'd4);
    checkOutput("str_data4", reg_write_data, 32'h104);
    tick();
    checkOutput("str_idle", 32'(reg_write_select), 32'd0);

    // Two writes to x6 keep it busy until both have drained
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 3'b010, 2'd0, 32'h61);
    tick();
    applyStimulus(1'b1, 5'd6, 32'h62, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    tick();
    idle();
    checkOutput("dup_busy1", busy_mask, 32'h0000_0040);
    checkOutput("dup_data1", reg_write_data, 32'h61);
    tick();
    checkOutput("dup_busy2", busy_mask, 32'h0000_0040);
    checkOutput("dup_data2", reg_write_data, 32'h62);
    tick();
    checkOutput("dup_busy3", busy_mask, 32'd0);

    // Illegal funct3 load to x7
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 3'b011, 2'd0, 32'h1234_5678);
    tick();
    idle();
    checkOutput("ill_err", 32'(ld_err), 32'd1);
    checkOutput("ill_busy", busy_mask, 32'h0000_0080);
    tick();
    checkOutput("ill_err_clr", 32'(ld_err), 32'd0);
    checkOutput("ill_sel", 32'(reg_write_select), 32'd7);
    checkOutput("ill_data", reg_write_data, 32'd0);
    tick();

    // Illegal funct3 to x0 still flags, but writes nothing
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 3'b111, 2'd0, 32'hFFFF_FFFF);
    tick();
    idle();
    checkOutput("ill0_err", 32'(ld_err), 32'd1);
    checkOutput("ill0_busy", busy_mask, 32'd0);
    tick();
    checkOutput("ill0_sel", 32'(reg_write_select), 32'd0);

    // ALU write to x0 is accepted and dropped
    applyStimulus(1'b1, 5'd0, 32'hABCD_0000, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    checkOutput("x0_rdy", 32'(alu_ready), 32'd1);
    tick();
    idle();
    checkOutput("x0_busy", busy_mask, 32'd0);
    tick();
    checkOutput("x0_sel", 32'(reg_write_select), 32'd0);
    checkOutput("x0_data", reg_write_data, 32'd0);

    // Reset while writes are queued discards them
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    tick();
    applyStimulus(1'b1, 5'd10, 32'hAA, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    tick();
    idle();
    checkOutput("flush_pre_busy", busy_mask, 32'h0000_0600);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("flush_sel", 32'(reg_write_select), 32'd0);
    checkOutput("flush_busy", busy_mask, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("flush_after%0d", i), 32'(reg_write_select), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
